tpu_conv_window: RTL and testbench

TPU_CONV_WINDOW -- requirements
Module: tpu_conv_window

---
 rtl/tpu_conv_window.sv | 143 ++++++++++++++
 tb/tb_tpu_conv_window.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_conv_window.sv
// 5x5 sliding-window generator: raster Float8 pixels in, 25-element windows out to the MAC.
// Latency: a window is presented the cycle after its bottom-right pixel is accepted.
// Backpressure: one-deep output; pix_ready = !win_valid || win_ready, held low in DONE until the last window drains.
// Optional: define TPU_CONV_WINDOW_POS_EN to add win_row/win_col output-map coordinates.
module tpu_conv_window #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   pix_data,
  input  logic         pix_valid,
  output logic         pix_ready,
  output logic [199:0] win_data,
  output logic         win_valid,
  input  logic         win_ready,
`ifdef TPU_CONV_WINDOW_POS_EN
  output logic [5:0]   win_row,
  output logic [5:0]   win_col,
`endif
  output logic         frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic [1:0] {FILL, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          ready_en;
  logic          acc, col_last, row_last, emit;

  // lb[0] holds the row four above the current one, lb[3] the row just above.
  logic [7:0]    lb  [4][IMG_W];
  logic [7:0]    win [5][5];

  assign acc      = pix_valid && pix_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign emit     = acc && (row >= RW'(4)) && (col >= CW'(4));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state: fill four rows, run to the last pixel, then drain the final window.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (acc && row == RW'(3) && col_last) state_nxt = RUN;
      RUN:     if (acc && row_last && col_last)      state_nxt = DONE;
      DONE:    if (win_valid && win_ready)           state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Output decode: input accepted only when out of reset, not draining, and the output slot frees up.
  always_comb begin
    pix_ready = ready_en && (state != DONE) && (!win_valid || win_ready);
  end

  // ready_en keeps pix_ready low while reset is asserted and raises it on the first clock after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  // Pixel position counters; they wrap to (0,0) after the last pixel of a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      col <= col_last ? '0 : col + 1'b1;
      if (col_last) row <= row_last ? '0 : row + 1'b1;
    end
  end

  // Line buffers shift one row up per column position; left unreset so they map to plain RAM.
  always_ff @(posedge clk) begin
    if (acc) begin
      lb[0][col] <= lb[1][col];
      lb[1][col] <= lb[2][col];
      lb[2][col] <= lb[3][col];
      lb[3][col] <= pix_data;
    end
  end

  // Window shifts left on every accepted pixel, new right column from line buffers plus the live pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++)
          win[r][c] <= 8'h00;
    end else if (acc) begin
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 4; c++)
          win[r][c] <= win[r][c+1];
      for (int r = 0; r < 4; r++)
        win[r][4] <= lb[r][col];
      win[4][4] <= pix_data;
    end
  end

  // The window registers double as the output slot: they cannot shift while a window is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         win_valid <= 1'b0;
    else if (emit)      win_valid <= 1'b1;
    else if (win_ready) win_valid <= 1'b0;
  end

`ifdef TPU_CONV_WINDOW_POS_EN
  // Output-map coordinates travel with the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_row <= 6'd0;
      win_col <= 6'd0;
    end else if (emit) begin
      win_row <= 6'(row) - 6'd4;
      win_col <= 6'(col) - 6'd4;
    end
  end
`endif

  // End-of-frame pulse the cycle after the final window is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done <= 1'b0;
    else        frame_done <= (state == DONE) && win_valid && win_ready;
  end

  // Flatten: element 5*r+c, row 0 / column 0 oldest.
  always_comb begin
    win_data = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        win_data[8*(5*r+c) +: 8] = win[r][c];
  end

endmodule

// File: tb/tb_tpu_conv_window.sv
// Bench for tpu_conv_window: 28x28 instance driven with (r*28+c) mod 256 frames, plus a 5x5 instance.
// Checks windows against a pixel-formula golden model, stall hold, mid-frame reset and frame_done timing.
// Compile with TPU_CONV_WINDOW_POS_EN defined to also check win_row/win_col.
module tb_tpu_conv_window;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   pix_data;
  logic         pix_valid, pix_ready, win_valid, win_ready, frame_done;
  logic [199:0] win_data;
  logic [7:0]   s_pix_data;
  logic         s_pix_valid, s_pix_ready, s_win_valid, s_win_ready, s_frame_done;
  logic [199:0] s_win_data;
`ifdef TPU_CONV_WINDOW_POS_EN
  logic [5:0]   win_row, win_col, s_win_row, s_win_col;
`endif

  always #5 clk = ~clk;

  tpu_conv_window #(.IMG_W(28), .IMG_H(28)) dut (
    .clk(clk), .rst_n(rst_n), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .win_data(win_data), .win_valid(win_valid), .win_ready(win_ready),
`ifdef TPU_CONV_WINDOW_POS_EN
    .win_row(win_row), .win_col(win_col),
`endif
    .frame_done(frame_done));

  tpu_conv_window #(.IMG_W(5), .IMG_H(5)) dut_s (
    .clk(clk), .rst_n(rst_n), .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
    .win_data(s_win_data), .win_valid(s_win_valid), .win_ready(s_win_ready),
`ifdef TPU_CONV_WINDOW_POS_EN
    .win_row(s_win_row), .win_col(s_win_col),
`endif
    .frame_done(s_frame_done));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Golden: window k sits at output (k/24, k%24); element i is pixel (orow+i/5, ocol+i%5).
  function automatic logic [199:0] gold_win(input int k);
    logic [199:0] w;
    int orow, ocol, v;
    orow = k / 24;
    ocol = k % 24;
    w = '0;
    for (int i = 0; i < 25; i++) begin
      v = ((orow + i / 5) * 28 + ocol + i % 5) % 256;
      w[8*i +: 8] = 8'(v);
    end
    return w;
  endfunction

  // Monitor: sampled on the falling edge, capturing transfers that complete at the next rising edge.
  logic [199:0] cap [4096];
  int ncap = 0, fd_cnt = 0, cyc = 0, acc_cyc = 0, fd_cyc = 0;
  logic [5:0] last_row, last_col;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (rst_n && win_valid && win_ready) begin
      if (ncap < 4096) cap[ncap] = win_data;
`ifdef TPU_CONV_WINDOW_POS_EN
      last_row = win_row;
      last_col = win_col;
`endif
      ncap++;
      acc_cyc = cyc;
    end
    if (rst_n && frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  int base = 0;

  // Drives one 28x28 frame; rst_at >= 0 aborts the frame with a reset pulse at that pixel.
  task automatic run_frame(input bit rv, input bit rr, input bit stall, input int rst_at);
    int p = 0, guard = 0, fdb;
    bit stalled = 0;
    logic [199:0] held;
    base = ncap;
    fdb  = fd_cnt;
    while (p < 784 && guard < 20000) begin
      if (rst_at >= 0 && p == rst_at) begin
        chk("pre_rst_valid", 200'(win_valid), 200'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 200'(win_valid), 200'(0));
        chk("rst_async_ready", 200'(pix_ready), 200'(0));
        chk("rst_async_data", win_data, '0);
        pix_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release_ready", 200'(pix_ready), 200'(1));
        chk("rst_no_frame_done", 200'(fd_cnt - fdb), 200'(0));
        return;
      end
      if (stall && !stalled && win_valid && (ncap - base) >= 100) begin
        held = win_data;
        win_ready = 1'b0;
        pix_valid = 1'b1;
        pix_data = p[7:0];
        for (int s = 0; s < 10; s++) begin
          @(negedge clk);
          chk($sformatf("stall_ready_%0d", s), 200'(pix_ready), 200'(0));
          chk($sformatf("stall_data_%0d", s), win_data, held);
          @(posedge clk); #1;
        end
        stalled = 1'b1;
      end
      pix_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_data  = p[7:0];
      win_ready = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (pix_valid && pix_ready) p++;
      @(posedge clk); #1;
      guard++;
    end
    pix_valid = 1'b0;
    win_ready = 1'b1;
    while (fd_cnt == fdb && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("frame_timeout", 200'(guard < 20000), 200'(1));
    chk("window_count", 200'(ncap - base), 200'(576));
    for (int k = 0; k < 576 && base + k < ncap; k++)
      chk($sformatf("win_%0d", k), cap[base + k], gold_win(k));
    chk("frame_done_once", 200'(fd_cnt - fdb), 200'(1));
    chk("frame_done_timing", 200'(fd_cyc), 200'(acc_cyc + 1));
  endtask

  typedef struct {
    int         k;
    int         i;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [9];

  initial begin
    logic [199:0] sw, sexp;
    int sp, scnt, sfd;
    // Hand-computed samples from the first frame: {window, element, value}.
    tbl[0] = '{0,   0,  8'd0};
    tbl[1] = '{0,   6,  8'd29};
    tbl[2] = '{0,   24, 8'd116};
    tbl[3] = '{1,   0,  8'd1};
    tbl[4] = '{23,  24, 8'd139};
    tbl[5] = '{24,  0,  8'd28};
    tbl[6] = '{300, 12, 8'd150};
    tbl[7] = '{575, 24, 8'd15};
    tbl[8] = '{575, 0,  8'd155};

    rst_n = 1'b0;
    pix_valid = 1'b0; pix_data = 8'h00; win_ready = 1'b0;
    s_pix_valid = 1'b0; s_pix_data = 8'h00; s_win_ready = 1'b1;
    #3;
    chk("reset_win_valid", 200'(win_valid), 200'(0));
    chk("reset_frame_done", 200'(frame_done), 200'(0));
    chk("reset_pix_ready", 200'(pix_ready), 200'(0));
    chk("reset_win_data", win_data, '0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 200'(pix_ready), 200'(1));

    run_frame(1'b0, 1'b0, 1'b0, -1);
    for (int n = 0; n < 9; n++)
      chk($sformatf("tbl_%0d", n), 200'(cap[base + tbl[n].k][8*tbl[n].i +: 8]), 200'(tbl[n].exp));
`ifdef TPU_CONV_WINDOW_POS_EN
    chk("last_win_row", 200'(last_row), 200'(23));
    chk("last_win_col", 200'(last_col), 200'(23));
`endif

    run_frame(1'b0, 1'b0, 1'b1, -1);
    run_frame(1'b1, 1'b1, 1'b0, -1);
    run_frame(1'b0, 1'b0, 1'b0, 300);
    run_frame(1'b0, 1'b0, 1'b0, -1);

    // 5x5 image: exactly one window equal to the 25 pixels in order.
    sexp = '0;
    for (int i = 0; i < 25; i++) sexp[8*i +: 8] = 8'(i * 7 + 3);
    sp = 0; scnt = 0; sfd = 0; sw = '0;
    s_win_ready = 1'b1;
    for (int t = 0; t < 60; t++) begin
      s_pix_valid = (sp < 25);
      s_pix_data  = 8'(sp * 7 + 3);
      @(negedge clk);
      if (s_pix_valid && s_pix_ready) sp++;
      if (s_win_valid && s_win_ready) begin
        scnt++;
        sw = s_win_data;
      end
      if (s_frame_done) sfd++;
      @(posedge clk); #1;
    end
    chk("small_pixels", 200'(sp), 200'(25));
    chk("small_count", 200'(scnt), 200'(1));
    chk("small_window", sw, sexp);
    chk("small_frame_done", 200'(sfd), 200'(1));
`ifdef TPU_CONV_WINDOW_POS_EN
    chk("small_row", 200'(s_win_row), 200'(0));
    chk("small_col", 200'(s_win_col), 200'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
